// File: rtl/virtio_notify_sched.sv
// Round-robin scheduler turning virtio Queue Notify writes into virtqueue
// engine requests, followed by an optional MSI-X interrupt request per service.
module virtio_notify_sched #(
    parameter int NUM_QUEUES = 3,
    parameter int QIDX_W     = 16,
    parameter int PFN_W      = 32,
    parameter int VEC_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        soft_rst,
    input  logic                        drv_ok,
    input  logic                        notify_valid,
    input  logic [QIDX_W-1:0]           notify_qidx,
    input  logic [NUM_QUEUES*PFN_W-1:0] queue_pfn,
    input  logic [NUM_QUEUES*VEC_W-1:0] queue_vec,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [QIDX_W-1:0]           req_qidx,
    output logic [PFN_W-1:0]            req_pfn,
    input  logic                        svc_done,
    output logic                        irq_valid,
    input  logic                        irq_ready,
    output logic [VEC_W-1:0]            irq_vec,
    output logic [NUM_QUEUES-1:0]       pending,
    output logic                        busy,
    output logic                        err_drop
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, IRQ} state_t;

    localparam logic [VEC_W-1:0] NO_VECTOR = VEC_W'(16'hFFFF);

    state_t                  state, state_nxt;
    logic [QIDX_W-1:0]       rr_ptr, rr_nxt, rr_after;
    logic                    req_valid_nxt, irq_valid_nxt, load;
    logic                    sel_found, accept, drop;
    logic [QIDX_W-1:0]       sel_q;
    logic [PFN_W-1:0]        sel_pfn, notify_pfn;
    logic [VEC_W-1:0]        sel_vec;
    logic [NUM_QUEUES-1:0]   set_mask, clr_mask;

    // First pending queue at or above rr_ptr, otherwise the lowest one (wrap).
    always_comb begin
        sel_found = 1'b0;
        sel_q     = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (!sel_found && pending[q] && (QIDX_W'(q) >= rr_ptr)) begin
                sel_found = 1'b1;
                sel_q     = QIDX_W'(q);
            end
        end
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (!sel_found && pending[q]) begin
                sel_found = 1'b1;
                sel_q     = QIDX_W'(q);
            end
        end
    end

    always_comb begin
        sel_pfn    = '0;
        sel_vec    = '0;
        notify_pfn = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (sel_q == QIDX_W'(q)) begin
                sel_pfn = queue_pfn[q*PFN_W +: PFN_W];
                sel_vec = queue_vec[q*VEC_W +: VEC_W];
            end
            if (notify_qidx == QIDX_W'(q))
                notify_pfn = queue_pfn[q*PFN_W +: PFN_W];
        end
    end

    // soft_rst swallows a coincident notify without flagging it as dropped.
    assign accept = notify_valid && !soft_rst && drv_ok &&
                    (notify_qidx < QIDX_W'(NUM_QUEUES)) && (notify_pfn != '0);
    assign drop   = notify_valid && !soft_rst && !accept;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            set_mask[q] = accept && (notify_qidx == QIDX_W'(q));
            clr_mask[q] = load && (sel_q == QIDX_W'(q));
        end
    end

    assign rr_after = (req_qidx == QIDX_W'(NUM_QUEUES - 1)) ? '0 : req_qidx + QIDX_W'(1);

    always_comb begin
        state_nxt     = state;
        req_valid_nxt = req_valid;
        irq_valid_nxt = irq_valid;
        rr_nxt        = rr_ptr;
        load          = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    load          = 1'b1;
                    req_valid_nxt = 1'b1;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    req_valid_nxt = 1'b0;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (svc_done) begin
                    if (irq_vec == NO_VECTOR) begin
                        rr_nxt    = rr_after;
                        state_nxt = IDLE;
                    end else begin
                        irq_valid_nxt = 1'b1;
                        state_nxt     = IRQ;
                    end
                end
            end
            IRQ: begin
                if (irq_ready) begin
                    irq_valid_nxt = 1'b0;
                    rr_nxt        = rr_after;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            rr_ptr    <= '0;
            err_drop  <= 1'b0;
            req_valid <= 1'b0;
            irq_valid <= 1'b0;
            busy      <= 1'b0;
            req_qidx  <= '0;
            req_pfn   <= '0;
            irq_vec   <= '0;
        end else if (soft_rst) begin
            state     <= IDLE;
            pending   <= '0;
            rr_ptr    <= '0;
            err_drop  <= 1'b0;
            req_valid <= 1'b0;
            irq_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= (pending & ~clr_mask) | set_mask;
            rr_ptr    <= rr_nxt;
            err_drop  <= err_drop | drop;
            req_valid <= req_valid_nxt;
            irq_valid <= irq_valid_nxt;
            busy      <= (state_nxt != IDLE);
            if (load) begin
                req_qidx <= sel_q;
                req_pfn  <= sel_pfn;
                irq_vec  <= sel_vec;
            end
        end
    end

endmodule

// File: tb/tb_virtio_notify_sched.sv
// Directed bench for virtio_notify_sched: notify acceptance, round-robin order,
// handshake stability, soft reset and the no-vector interrupt skip.
module tb_virtio_notify_sched;

    localparam int NQ = 3;
    localparam int QW = 16;
    localparam int PW = 32;
    localparam int VW = 16;

    logic              clk = 1'b0;
    logic              rst, soft_rst, drv_ok, notify_valid;
    logic [QW-1:0]     notify_qidx;
    logic [NQ*PW-1:0]  queue_pfn;
    logic [NQ*VW-1:0]  queue_vec;
    logic              req_valid, req_ready, svc_done;
    logic [QW-1:0]     req_qidx;
    logic [PW-1:0]     req_pfn;
    logic              irq_valid, irq_ready;
    logic [VW-1:0]     irq_vec;
    logic [NQ-1:0]     pending;
    logic              busy, err_drop;

    int checks = 0;
    int errors = 0;

    virtio_notify_sched #(
        .NUM_QUEUES(NQ), .QIDX_W(QW), .PFN_W(PW), .VEC_W(VW)
    ) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .drv_ok(drv_ok),
        .notify_valid(notify_valid), .notify_qidx(notify_qidx),
        .queue_pfn(queue_pfn), .queue_vec(queue_vec),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_qidx(req_qidx), .req_pfn(req_pfn), .svc_done(svc_done),
        .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_vec(irq_vec),
        .pending(pending), .busy(busy), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle notify pulse; outputs are observed after the capturing edge.
    task automatic notify(input int q);
        notify_valid = 1'b1;
        notify_qidx  = QW'(q);
        step();
        notify_valid = 1'b0;
    endtask

    // Entered with the request already presented; runs it through the interrupt.
    task automatic serve_from_issue(input int q, input int pfn, input int vec);
        check("issue_valid", req_valid, 1);
        check("issue_qidx", req_qidx, q);
        check("issue_pfn", req_pfn, pfn);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check("wait_req_valid", req_valid, 0);
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        check("irq_valid", irq_valid, 1);
        check("irq_vec", irq_vec, vec);
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        check("irq_done", irq_valid, 0);
    endtask

    task automatic serve(input int q, input int pfn, input int vec);
        step();
        serve_from_issue(q, pfn, vec);
    endtask

    initial begin
        rst = 1'b1; soft_rst = 1'b0; drv_ok = 1'b0; notify_valid = 1'b0;
        notify_qidx = '0; req_ready = 1'b0; svc_done = 1'b0; irq_ready = 1'b0;
        queue_pfn = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        queue_vec = {16'd3, 16'd2, 16'd1};
        step();
        step();
        check("rst_req_valid", req_valid, 0);
        check("rst_irq_valid", irq_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_err_drop", err_drop, 0);
        check("rst_req_qidx", req_qidx, 0);
        check("rst_req_pfn", req_pfn, 0);
        check("rst_irq_vec", irq_vec, 0);
        rst = 1'b0;
        drv_ok = 1'b1;

        // Single service of queue 1, interrupt held while three more notifies land
        notify(1);
        check("t1_pending", pending, 3'b010);
        check("t1_no_req_yet", req_valid, 0);
        step();
        check("t1_req_valid", req_valid, 1);
        check("t1_req_qidx", req_qidx, 1);
        check("t1_req_pfn", req_pfn, 32'h2000);
        check("t1_pending_clr", pending, 0);
        check("t1_busy", busy, 1);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check("t1_wait", req_valid, 0);
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        check("t1_irq_valid", irq_valid, 1);
        check("t1_irq_vec", irq_vec, 2);
        notify(0);
        notify(1);
        notify(2);
        check("t1_irq_held", irq_valid, 1);
        check("t2_pending_all", pending, 3'b111);
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        check("t1_irq_done", irq_valid, 0);
        check("t1_idle", busy, 0);
        check("t1_rr_ptr", dut.rr_ptr, 2);

        // Round-robin from rr_ptr=2
        serve(2, 32'h3000, 3);
        serve(0, 32'h1000, 1);
        serve(1, 32'h2000, 2);
        check("t2_pending_end", pending, 0);

        // Dropped notifies: out of range, zero PFN, driver not ready
        notify(3);
        check("t3_err_range", err_drop, 1);
        queue_pfn[0 +: PW] = '0;
        notify(0);
        queue_pfn[0 +: PW] = 32'h1000;
        drv_ok = 1'b0;
        notify(1);
        drv_ok = 1'b1;
        step();
        check("t3_pending", pending, 0);
        check("t3_req_valid", req_valid, 0);
        check("t3_err_sticky", err_drop, 1);
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        check("t3_err_clr", err_drop, 0);
        check("t3_rr_clr", dut.rr_ptr, 0);

        // Backpressure in ISSUE with a notify on queue 2 meanwhile
        notify(1);
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                notify_valid = 1'b1;
                notify_qidx  = 16'd2;
            end
            step();
            notify_valid = 1'b0;
            check("t4_hold_valid", req_valid, 1);
            check("t4_hold_qidx", req_qidx, 1);
            check("t4_hold_pfn", req_pfn, 32'h2000);
        end
        check("t4_pending2", pending, 3'b100);
        serve_from_issue(1, 32'h2000, 2);
        serve(2, 32'h3000, 3);
        check("t4_pending_end", pending, 0);

        // soft_rst in WAIT with pending=101 and err_drop set
        notify(5);
        check("t5_err", err_drop, 1);
        notify(1);
        notify(0);
        notify(2);
        check("t5_issue_qidx", req_qidx, 1);
        check("t5_pending", pending, 3'b101);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check("t5_in_wait_busy", busy, 1);
        soft_rst = 1'b1;
        notify_valid = 1'b1;
        notify_qidx = 16'd2;
        step();
        soft_rst = 1'b0;
        notify_valid = 1'b0;
        check("t5_pending_clr", pending, 0);
        check("t5_err_clr", err_drop, 0);
        check("t5_busy", busy, 0);
        check("t5_req_valid", req_valid, 0);
        check("t5_irq_valid", irq_valid, 0);
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        check("t5_late_done_irq", irq_valid, 0);
        step();
        check("t5_late_done_busy", busy, 0);
        check("t5_late_done_irq2", irq_valid, 0);

        // Queue 1 with no MSI-X vector: interrupt phase skipped
        queue_vec[VW +: VW] = 16'hFFFF;
        notify(1);
        step();
        check("t6_req_qidx", req_qidx, 1);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        check("t6_no_irq", irq_valid, 0);
        check("t6_idle", busy, 0);
        check("t6_rr_ptr", dut.rr_ptr, 2);
        step();
        check("t6_no_irq_later", irq_valid, 0);
        queue_vec[VW +: VW] = 16'd2;

        // Notify colliding with the clear of the same queue keeps it pending
        notify(0);
        notify(0);
        check("t7_req_qidx", req_qidx, 0);
        check("t7_pending_kept", pending, 3'b001);
        serve_from_issue(0, 32'h1000, 1);
        serve(0, 32'h1000, 1);
        check("t7_pending_end", pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
